relay_frame_tx: RTL and testbench

Transmit-side framer for the relay link. It takes payload bytes from the ARM/SSP side and serialises them onto the relay line, one bit per DIV clocks, MSB first. Each frame is wrapped in the start marker and end trailer that the relay receive path detects, using reader or tag framing. The serial output drives the relay encoder input in place of raw pass-through data while a frame is being sent.

---
 rtl/relay_frame_tx_pkg.sv | 23 ++
 rtl/relay_frame_tx_if.sv | 10 +
 rtl/relay_byte_fifo.sv | 47 ++++
 rtl/relay_frame_tx.sv | 144 ++++++++++++++
 tb/tb_relay_frame_tx.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/relay_frame_tx_pkg.sv
// Shared constants and types for the relay transmit framer.
package relay_frame_tx_pkg;

    localparam logic [7:0] READER_START_BYTE   = 8'hC0;
    localparam logic [7:0] TAG_START_BYTE      = 8'hF0;
    localparam int         READER_TRAILER_BITS = 16;
    localparam int         TAG_TRAILER_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_START,
        ST_PAYLOAD,
        ST_TRAILER,
        ST_GAP
    } tx_state_e;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/relay_frame_tx_if.sv
// Payload byte handshake between the ARM/SSP side and the relay framer.
interface relay_frame_tx_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, output byte_last, input byte_ready);
    modport slave  (input byte_in, input byte_valid, input byte_last, output byte_ready);
endinterface

// File: rtl/relay_byte_fifo.sv
// Small synchronous FIFO holding {last, byte} payload entries; head is read combinationally.
module relay_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_i,
    input  logic [W-1:0] din_i,
    input  logic         rd_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          wr_en, rd_en;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    // A write on a full FIFO is only taken when a read frees the slot in the same clk.
    assign wr_en   = wr_i && (!full_o || rd_i);
    assign rd_en   = rd_i && !empty_o;
    assign dout_o  = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wptr_q] <= din_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (rd_en) rptr_q <= rptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/relay_frame_tx.sv
// Relay link transmit framer: preamble, start marker, MSB-first payload, trailer and
// inter-frame gap, one bit per DIV clks.
module relay_frame_tx
    import relay_frame_tx_pkg::*;
#(
    parameter int DIV           = 16,
    parameter int MIN_IDLE_BITS = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode_reader,
    relay_frame_tx_if.slave bif,
    output logic            tx_out,
    output logic            tx_active,
    output logic            underrun
);
    localparam int         DW        = $clog2(DIV + 1);
    localparam logic [7:0] IDLE_LAST = 8'(MIN_IDLE_BITS - 1);

    logic [DW-1:0] div_q;
    logic          bit_strobe;
    tx_state_e     state_q, state_d;
    logic [7:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          last_q, last_d;
    logic          mode_q, mode_d;
    logic          underrun_q, underrun_d;
    logic          fifo_full, fifo_empty, fifo_pop;
    fifo_entry_t   fifo_head;
    logic [7:0]    trail_last;

    assign bit_strobe = (div_q == DW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset || bit_strobe) div_q <= '0;
        else                      div_q <= div_q + 1'b1;
    end

    assign bif.byte_ready = !fifo_full;

    relay_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fifo_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .wr_i    (bif.byte_valid && bif.byte_ready),
        .din_i   ({bif.byte_last, bif.byte_in}),
        .rd_i    (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign trail_last = mode_q ? 8'(READER_TRAILER_BITS - 1) : 8'(TAG_TRAILER_BITS - 1);

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        last_d     = last_q;
        mode_d     = mode_q;
        underrun_d = 1'b0;
        fifo_pop   = 1'b0;
        if (bit_strobe) begin
            bitcnt_d = bitcnt_q + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    bitcnt_d = '0;
                    if (!fifo_empty) begin
                        state_d = ST_PREAMBLE;
                        mode_d  = mode_reader;
                    end
                end
                ST_PREAMBLE: if (bitcnt_q == IDLE_LAST) begin
                    state_d  = ST_START;
                    bitcnt_d = '0;
                    shreg_d  = mode_q ? READER_START_BYTE : TAG_START_BYTE;
                end
                ST_START, ST_PAYLOAD: begin
                    if (bitcnt_q != 8'd7) begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                    end else begin
                        bitcnt_d = '0;
                        // A frame only starts with a byte queued, so START always finds a head entry.
                        if (state_q == ST_PAYLOAD && last_q) begin
                            state_d = ST_TRAILER;
                        end else if (!fifo_empty) begin
                            state_d  = ST_PAYLOAD;
                            fifo_pop = 1'b1;
                            shreg_d  = fifo_head.data;
                            last_d   = fifo_head.last;
                        end else begin
                            state_d    = ST_TRAILER;
                            underrun_d = 1'b1;
                        end
                    end
                end
                ST_TRAILER: if (bitcnt_q == trail_last) begin
                    state_d  = ST_GAP;
                    bitcnt_d = '0;
                end
                ST_GAP: if (bitcnt_q == IDLE_LAST) begin
                    bitcnt_d = '0;
                    // Go straight to PREAMBLE when a frame is queued, so the spacing is exactly GAP+PREAMBLE.
                    if (!fifo_empty) begin
                        state_d = ST_PREAMBLE;
                        mode_d  = mode_reader;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    bitcnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            last_q     <= 1'b0;
            mode_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            last_q     <= last_d;
            mode_q     <= mode_d;
            underrun_q <= underrun_d;
        end
    end

    assign tx_out    = (state_q == ST_START || state_q == ST_PAYLOAD) && shreg_q[7];
    assign tx_active = (state_q == ST_PREAMBLE) || (state_q == ST_START) ||
                       (state_q == ST_PAYLOAD)  || (state_q == ST_TRAILER);
    assign underrun  = underrun_q;
endmodule

// File: tb/tb_relay_frame_tx.sv
// Randomized frame traffic checked bit-by-bit against a frame-level model of the relay line.
module tb_relay_frame_tx;
    localparam int DIV = 16;
    localparam int NF  = 15;
    localparam int LIM = 5000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic mode_reader = 1'b0;
    logic tx_out, tx_active, underrun;

    relay_frame_tx_if bif();

    relay_frame_tx #(.DIV(DIV), .MIN_IDLE_BITS(16), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode_reader (mode_reader),
        .bif         (bif),
        .tx_out      (tx_out),
        .tx_active   (tx_active),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int   tests = 0, bad = 0, cyc = 0, ur_cnt = 0;
    int   done_frame = -1, trl_frame = -1, started_frame = -1;
    logic idle_hi = 1'b0;

    logic [7:0] f_bytes [NF][6];
    int         f_len   [NF];
    bit         f_mode  [NF];
    bit         f_lastok[NF];
    bit         f_b2b   [NF];
    int         t_wr    [NF];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (underrun) ur_cnt <= ur_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic l, output int wc);
        int n = 0;
        bif.byte_in    = d;
        bif.byte_last  = l;
        bif.byte_valid = 1'b1;
        while (!bif.byte_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk("wr_ready", bif.byte_ready, 1);
        @(posedge clk);
        #1 wc = cyc;
        @(negedge clk);
        bif.byte_valid = 1'b0;
    endtask

    task automatic wait_rise(input int lim, output int waited);
        waited = 0;
        while (!tx_active && waited < lim) begin
            if (tx_out) idle_hi = 1'b1;
            @(negedge clk);
            waited++;
        end
        chk("rise", tx_active, 1);
    endtask

    // Called at the first negedge of a bit slot; the whole slot must hold the expected value.
    task automatic check_bit(input int f, input int i, input logic [1:0] exp);
        logic [1:0] obs, cur;
        obs = {tx_out, tx_active};
        for (int k = 1; k < DIV; k++) begin
            @(negedge clk);
            cur = {tx_out, tx_active};
            if (obs == exp && cur != exp) obs = cur;
        end
        chk($sformatf("f%0d_bit%0d", f, i), obs, exp);
        @(negedge clk);
    endtask

    task automatic run_checker(input int lo, input int hi);
        for (int f = lo; f <= hi; f++) begin : frame_blk
            logic [1:0] q[$];
            logic [7:0] sb;
            int         trl_idx, w, ur0;
            q = {};
            repeat (16) q.push_back(2'b01);
            sb = f_mode[f] ? 8'hC0 : 8'hF0;
            for (int b = 7; b >= 0; b--) q.push_back({sb[b], 1'b1});
            for (int i = 0; i < f_len[f]; i++)
                for (int b = 7; b >= 0; b--) q.push_back({f_bytes[f][i][b], 1'b1});
            trl_idx = q.size();
            repeat (f_mode[f] ? 16 : 8) q.push_back(2'b01);
            repeat (16) q.push_back(2'b00);

            wait_rise(f_b2b[f] ? 2 : LIM, w);
            if (f_b2b[f]) chk("b2b_spacing", w, 0);
            else          chk("latency_ok", (cyc - t_wr[f] <= DIV + 1), 1);
            started_frame = f;
            ur0 = ur_cnt;
            for (int i = 0; i < q.size(); i++) begin
                if (i == trl_idx) begin
                    trl_frame = f;
                    chk($sformatf("f%0d_underrun_pulse", f), underrun, !f_lastok[f]);
                end
                check_bit(f, i, q[i]);
            end
            chk($sformatf("f%0d_underrun_cnt", f), ur_cnt - ur0, f_lastok[f] ? 0 : 1);
            done_frame = f;
        end
    endtask

    task automatic run_producer(input int lo, input int hi);
        for (int f = lo; f <= hi; f++) begin : prod_blk
            int n, wc;
            n = 0;
            @(negedge clk);
            if (f_b2b[f]) begin
                while (trl_frame < f - 1 && n < LIM) begin @(negedge clk); n++; end
            end else begin
                while (done_frame < f - 1 && n < LIM) begin @(negedge clk); n++; end
                repeat ($urandom_range(0, 3 * DIV)) @(negedge clk);
            end
            mode_reader = f_mode[f];
            for (int i = 0; i < f_len[f]; i++) begin
                wr_byte(f_bytes[f][i], (i == f_len[f] - 1) && f_lastok[f], wc);
                if (i == 0) t_wr[f] = wc;
                if (i == 3 && f_len[f] > 4) chk("ready_full", bif.byte_ready, 0);
            end
            n = 0;
            while (started_frame < f && n < LIM) begin @(negedge clk); n++; end
            // The framing mode was latched at frame start; wiggling it now must not matter.
            mode_reader = 1'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wc, w;
        bif.byte_in    = '0;
        bif.byte_valid = 1'b0;
        bif.byte_last  = 1'b0;

        f_mode[0] = 1; f_len[0] = 2; f_lastok[0] = 1; f_b2b[0] = 0;
        f_bytes[0][0] = 8'h12; f_bytes[0][1] = 8'h34;
        f_mode[1] = 0; f_len[1] = 1; f_lastok[1] = 1; f_b2b[1] = 0;
        f_bytes[1][0] = 8'hA5;
        f_mode[2] = 1; f_len[2] = 1; f_lastok[2] = 0; f_b2b[2] = 0;
        f_bytes[2][0] = 8'h55;
        f_mode[3] = 1; f_len[3] = 2; f_lastok[3] = 1; f_b2b[3] = 0;
        f_bytes[3][0] = 8'h3C; f_bytes[3][1] = 8'h81;
        f_mode[4] = 0; f_len[4] = 1; f_lastok[4] = 1; f_b2b[4] = 1;
        f_bytes[4][0] = 8'h7E;
        f_mode[5] = 1; f_len[5] = 6; f_lastok[5] = 1; f_b2b[5] = 0;
        for (int i = 0; i < 6; i++) f_bytes[5][i] = 8'(8'h01 + 8'(i));
        for (int f = 6; f < 14; f++) begin
            f_mode[f]   = 1'($urandom);
            f_len[f]    = $urandom_range(1, 6);
            f_lastok[f] = ($urandom % 4) != 0;
            f_b2b[f]    = 1'($urandom);
            for (int i = 0; i < 6; i++) f_bytes[f][i] = 8'($urandom);
        end
        f_mode[14] = 0; f_len[14] = 1; f_lastok[14] = 1; f_b2b[14] = 0;
        f_bytes[14][0] = 8'h42;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_out", tx_out, 0);
        chk("rst_tx_active", tx_active, 0);
        chk("rst_byte_ready", bif.byte_ready, 1);
        chk("rst_underrun", underrun, 0);
        reset = 1'b1;

        fork
            run_producer(0, 13);
            run_checker(0, 13);
        join

        // Truncate a reader frame in the middle of its second payload byte.
        @(negedge clk);
        mode_reader = 1'b1;
        wr_byte(8'h11, 1'b0, wc);
        wr_byte(8'h3F, 1'b0, wc);
        wr_byte(8'h33, 1'b1, wc);
        wait_rise(LIM, w);
        repeat ((16 + 8 + 8 + 3) * DIV) @(negedge clk);
        chk("mid_active", tx_active, 1);
        chk("mid_tx_out", tx_out, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("trunc_tx_out", tx_out, 0);
        chk("trunc_tx_active", tx_active, 0);
        chk("trunc_byte_ready", bif.byte_ready, 1);
        chk("trunc_underrun", underrun, 0);
        @(negedge clk);
        reset = 1'b1;

        fork
            run_producer(14, 14);
            run_checker(14, 14);
        join
        chk("idle_quiet", idle_hi, 0);

        $display("test done: total=%0d bad=%0d", tests, bad);
        $finish;
    end
endmodule
